// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the UART transmitter: write port, frame config, status and line.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic                 i_fWr;
  logic [DATA_BITS-1:0] i_Data;
  logic                 i_ParityEn;
  logic                 i_ParityOdd;
  logic                 i_TwoStop;
  logic                 i_fClrOvf;
  logic                 o_fFull;
  logic                 o_fEmpty;
  logic [LW-1:0]        o_Level;
  logic                 o_fBusy;
  logic                 o_fDone;
  logic                 o_fOverflow;
  logic                 o_Tx;

  modport master (
    output i_fWr, i_Data, i_ParityEn, i_ParityOdd, i_TwoStop, i_fClrOvf,
    input  o_fFull, o_fEmpty, o_Level, o_fBusy, o_fDone, o_fOverflow, o_Tx
  );

  modport slave (
    input  i_fWr, i_Data, i_ParityEn, i_ParityOdd, i_TwoStop, i_fClrOvf,
    output o_fFull, o_fEmpty, o_Level, o_fBusy, o_fDone, o_fOverflow, o_Tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a transmit FIFO; data width, parity and stop bits per frame.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic           i_Clk,
  input logic           i_Rst,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 full, empty, ovf;
  logic                 push_c, pop_c;
  logic [LW-1:0]        level_nxt_c;
  logic [DATA_BITS-1:0] head_c;

  // Frame engine
  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 par_en_q, par_en_nxt;
  logic                 par_odd_q, par_odd_nxt;
  logic                 two_q, two_nxt;
  logic                 tx_q, tx_nxt;
  logic                 done_q, done_nxt;
  logic                 busy_q;
  logic                 bit_end_c, load_c;

  // Full check uses pre-edge state, so a pop in the same cycle does not make room
  assign push_c      = bus.i_fWr && !full;
  assign level_nxt_c = level + LW'(push_c) - LW'(pop_c);
  assign head_c      = mem[rd_ptr];

  // FIFO data array, no reset needed on storage
  always_ff @(posedge i_Clk) begin
    if (push_c) mem[wr_ptr] <= bus.i_Data;
  end

  // FIFO pointers, occupancy flags and sticky overflow
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt_c;
      full  <= (level_nxt_c == LW'(FIFO_DEPTH));
      empty <= (level_nxt_c == '0);
      if (bus.i_fWr && full) ovf <= 1'b1;
      else if (bus.i_fClrOvf) ovf <= 1'b0;
    end
  end

  // Next-state logic; line level and done are derived from the next state so they register cleanly
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_nxt     = bit_idx;
    data_nxt    = data_q;
    par_en_nxt  = par_en_q;
    par_odd_nxt = par_odd_q;
    two_nxt     = two_q;
    pop_c       = 1'b0;
    load_c      = 1'b0;
    tx_nxt      = 1'b1;
    done_nxt    = 1'b0;
    bit_end_c   = (cnt == CW'(CLKS_PER_BIT - 1));

    case (state)
      IDLE: begin
        if (!empty) load_c = 1'b1;
      end
      START: begin
        cnt_nxt = bit_end_c ? '0 : cnt + CW'(1);
        if (bit_end_c) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        cnt_nxt = bit_end_c ? '0 : cnt + CW'(1);
        if (bit_end_c) begin
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            state_nxt = par_en_q ? PARITY : STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_idx + BW'(1);
          end
        end
      end
      PARITY: begin
        cnt_nxt = bit_end_c ? '0 : cnt + CW'(1);
        if (bit_end_c) begin
          state_nxt = STOP;
          bit_nxt   = '0;
        end
      end
      STOP: begin
        cnt_nxt = bit_end_c ? '0 : cnt + CW'(1);
        if (bit_end_c) begin
          if (bit_idx == (two_q ? BW'(1) : BW'(0))) begin
            if (!empty) load_c = 1'b1;
            else        state_nxt = IDLE;
            bit_nxt = '0;
          end else begin
            bit_nxt = bit_idx + BW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Pop head and latch the frame configuration; config is frozen until the next pop
    if (load_c) begin
      pop_c       = 1'b1;
      data_nxt    = head_c;
      par_en_nxt  = bus.i_ParityEn;
      par_odd_nxt = bus.i_ParityOdd;
      two_nxt     = bus.i_TwoStop;
      state_nxt   = START;
      cnt_nxt     = '0;
      bit_nxt     = '0;
    end

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_nxt[bit_nxt];
      PARITY:  tx_nxt = (^data_nxt) ^ par_odd_nxt;
      default: tx_nxt = 1'b1;
    endcase

    done_nxt = (state_nxt == STOP) && (cnt_nxt == CW'(CLKS_PER_BIT - 1)) &&
               (bit_nxt == (two_nxt ? BW'(1) : BW'(0)));
  end

  // Frame engine state and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      two_q     <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      data_q    <= data_nxt;
      par_en_q  <= par_en_nxt;
      par_odd_q <= par_odd_nxt;
      two_q     <= two_nxt;
      tx_q      <= tx_nxt;
      done_q    <= done_nxt;
      busy_q    <= (state_nxt != IDLE);
    end
  end

  assign bus.o_fFull     = full;
  assign bus.o_fEmpty    = empty;
  assign bus.o_Level     = level;
  assign bus.o_fBusy     = busy_q;
  assign bus.o_fDone     = done_q;
  assign bus.o_fOverflow = ovf;
  assign bus.o_Tx        = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8-bit instance and 9-bit instance, both at 4 clocks per bit.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus ();
  uart_tx_fifo_if #(.DATA_BITS(9), .FIFO_DEPTH(16)) bus9 ();

  uart_tx_fifo #(
    .CLK_FREQ(50_000_000), .BAUD(12_500_000), .DATA_BITS(8), .FIFO_DEPTH(16)
  ) dut (
    .i_Clk(clk), .i_Rst(rst_n), .bus(bus.slave)
  );

  uart_tx_fifo #(
    .CLK_FREQ(50_000_000), .BAUD(12_500_000), .DATA_BITS(9), .FIFO_DEPTH(16)
  ) dut9 (
    .i_Clk(clk), .i_Rst(rst_n), .bus(bus9.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic get_tx(input bit sel);
    return sel ? bus9.o_Tx : bus.o_Tx;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? bus9.o_fDone : bus.o_fDone;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? bus9.o_fBusy : bus.o_fBusy;
  endfunction

  // Wait (bounded) for the line to drop; returns at the negedge of frame clock 1
  task automatic wait_start(input bit sel, input string tag);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (get_tx(sel) === 1'b0) found = 1;
    end
    check({tag, " start"}, 32'(found), 32'd1);
  endtask

  // Capture a frame starting at clock 1; exp bit 0 is the first bit on the line
  task automatic frame(input bit sel, input int nbits, input logic [15:0] exp, input string tag);
    logic [15:0] obs = '0;
    int          done_at = -1;
    int          ndone = 0;
    bit          unstable = 0;
    for (int c = 0; c < nbits * CPB; c++) begin
      if (c > 0) @(negedge clk);
      if (c % CPB == 0) obs[c / CPB] = get_tx(sel);
      else if (get_tx(sel) !== obs[c / CPB]) unstable = 1;
      if (get_done(sel) === 1'b1) begin
        ndone++;
        done_at = c + 1;
      end
    end
    check({tag, " bits"}, 32'(obs), 32'(exp));
    check({tag, " stable"}, 32'(unstable), 32'd0);
    check({tag, " done_at"}, 32'(done_at), 32'(nbits * CPB));
    check({tag, " done_n"}, 32'(ndone), 32'd1);
  endtask

  // Write one word from idle, check exact launch latency, the frame and the return to idle
  task automatic send_frame(input bit sel, input logic [8:0] w, input int nbits,
                            input logic [15:0] exp, input string tag);
    @(negedge clk);
    if (sel) begin bus9.i_fWr = 1'b1; bus9.i_Data = w; end
    else begin bus.i_fWr = 1'b1; bus.i_Data = w[7:0]; end
    @(negedge clk);
    bus.i_fWr  = 1'b0;
    bus9.i_fWr = 1'b0;
    check({tag, " pre_tx"}, 32'(get_tx(sel)), 32'd1);
    @(negedge clk);
    check({tag, " launch_tx"}, 32'(get_tx(sel)), 32'd0);
    check({tag, " busy"}, 32'(get_busy(sel)), 32'd1);
    frame(sel, nbits, exp, tag);
    @(negedge clk);
    check({tag, " idle_busy"}, 32'(get_busy(sel)), 32'd0);
    check({tag, " idle_tx"}, 32'(get_tx(sel)), 32'd1);
  endtask

  initial begin
    int lows;
    bus.i_fWr = 0;  bus.i_Data = '0;  bus.i_ParityEn = 0;  bus.i_ParityOdd = 0;
    bus.i_TwoStop = 0;  bus.i_fClrOvf = 0;
    bus9.i_fWr = 0; bus9.i_Data = '0; bus9.i_ParityEn = 0; bus9.i_ParityOdd = 0;
    bus9.i_TwoStop = 0; bus9.i_fClrOvf = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst tx", 32'(bus.o_Tx), 32'd1);
    check("rst empty", 32'(bus.o_fEmpty), 32'd1);
    check("rst full", 32'(bus.o_fFull), 32'd0);
    check("rst level", 32'(bus.o_Level), 32'd0);
    check("rst busy", 32'(bus.o_fBusy), 32'd0);
    check("rst done", 32'(bus.o_fDone), 32'd0);
    check("rst ovf", 32'(bus.o_fOverflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    send_frame(0, 9'h0A5, 10, 16'({1'b1, 8'hA5, 1'b0}), "t1_8n1");

    // parity even (A5 has four ones -> 0), odd -> 1, odd with two stops
    bus.i_ParityEn = 1;
    send_frame(0, 9'h0A5, 11, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), "t2_even");
    bus.i_ParityOdd = 1;
    send_frame(0, 9'h0A5, 11, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), "t2_odd");
    bus.i_TwoStop = 1;
    send_frame(0, 9'h0A5, 12, 16'({2'b11, 1'b1, 8'hA5, 1'b0}), "t2_odd2s");
    bus.i_ParityEn = 0; bus.i_ParityOdd = 0; bus.i_TwoStop = 0;
    repeat (2) @(negedge clk);

    // 18 back-to-back writes: overflow on the last, 17 contiguous frames on the line
    fork
      begin
        @(negedge clk);
        for (int i = 1; i <= 18; i++) begin
          if (i == 18) begin
            check("t3 full", 32'(bus.o_fFull), 32'd1);
            check("t3 level16", 32'(bus.o_Level), 32'd16);
            check("t3 ovf_pre", 32'(bus.o_fOverflow), 32'd0);
          end
          bus.i_fWr = 1'b1;
          bus.i_Data = 8'(8'h20 + i);
          @(negedge clk);
        end
        bus.i_fWr = 1'b0;
        check("t3 ovf_set", 32'(bus.o_fOverflow), 32'd1);
        check("t3 level_after_drop", 32'(bus.o_Level), 32'd16);
        bus.i_fClrOvf = 1'b1;
        @(negedge clk);
        bus.i_fClrOvf = 1'b0;
        check("t3 ovf_clr", 32'(bus.o_fOverflow), 32'd0);
      end
      begin
        wait_start(0, "t3");
        for (int k = 1; k <= 17; k++) begin
          if (k > 1) begin
            @(negedge clk);
            check($sformatf("t3 gap%0d", k), 32'(bus.o_Tx), 32'd0);
          end
          frame(0, 10, 16'({1'b1, 8'(8'h20 + k), 1'b0}), $sformatf("t3 w%0d", k));
        end
        @(negedge clk);
        check("t3 end_busy", 32'(bus.o_fBusy), 32'd0);
        check("t3 end_empty", 32'(bus.o_fEmpty), 32'd1);
      end
    join

    // Three queued frames, TwoStop toggled during the first
    fork
      begin
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
          bus.i_fWr = 1'b1;
          bus.i_Data = 8'(i);
          @(negedge clk);
        end
        bus.i_fWr = 1'b0;
        repeat (8) @(negedge clk);
        bus.i_TwoStop = 1'b1;
      end
      begin
        wait_start(0, "t4");
        frame(0, 10, 16'({1'b1, 8'h01, 1'b0}), "t4 f1");
        @(negedge clk);
        check("t4 gap2", 32'(bus.o_Tx), 32'd0);
        frame(0, 11, 16'({2'b11, 8'h02, 1'b0}), "t4 f2");
        @(negedge clk);
        check("t4 gap3", 32'(bus.o_Tx), 32'd0);
        frame(0, 11, 16'({2'b11, 8'h03, 1'b0}), "t4 f3");
        @(negedge clk);
        check("t4 end_busy", 32'(bus.o_fBusy), 32'd0);
        check("t4 end_done", 32'(bus.o_fDone), 32'd0);
      end
    join
    bus.i_TwoStop = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of data bit 0 with words still queued
    for (int i = 0; i < 5; i++) begin
      bus.i_fWr = 1'b1;
      bus.i_Data = 8'(8'h50 + i);
      @(negedge clk);
    end
    bus.i_fWr = 1'b0;
    repeat (2) @(negedge clk);
    check("t5 level_pre", 32'(bus.o_Level), 32'd4);
    check("t5 busy_pre", 32'(bus.o_fBusy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5 tx", 32'(bus.o_Tx), 32'd1);
    check("t5 level", 32'(bus.o_Level), 32'd0);
    check("t5 empty", 32'(bus.o_fEmpty), 32'd1);
    check("t5 busy", 32'(bus.o_fBusy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.o_Tx !== 1'b1 || bus.o_fBusy !== 1'b0) lows++;
    end
    check("t5 quiet", 32'(lows), 32'd0);
    send_frame(0, 9'h03C, 10, 16'({1'b1, 8'h3C, 1'b0}), "t5 new");

    // 9-bit instance: 0x1FF has nine ones, even parity bit 1, 48-clock frame
    bus9.i_ParityEn = 1'b1;
    send_frame(1, 9'h1FF, 12, 16'({1'b1, 1'b1, 9'h1FF, 1'b0}), "t6 9e1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO, configurable data width, and runtime-selectable parity and stop-bit count. It replaces the fixed 8N1 single-byte transmitter. Producers can queue up to FIFO_DEPTH words without waiting on the line. It sits between the system-side producer (command/telemetry logic) and the board TX pin.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s; derived CLKS_PER_BIT = CLK_FREQ / BAUD (integer division, 434 at defaults, must be >= 2)
DATA_BITS, 8, data bits per frame (5..9)
FIFO_DEPTH, 16, TX FIFO entries (power of two, >= 2)

Ports:
i_Clk  in  1  system clock; all logic on its rising edge
i_Rst  in  1  asynchronous, active-low reset
i_fWr  in  1  write strobe; pushes i_Data when FIFO not full
i_Data  in  DATA_BITS  word to queue
i_ParityEn  in  1  1 = append parity bit
i_ParityOdd  in  1  1 = odd parity, 0 = even (ignored when i_ParityEn = 0)
i_TwoStop  in  1  1 = two stop bits, 0 = one stop bit
i_fClrOvf  in  1  clears o_fOverflow
o_fFull  out  1  FIFO holds FIFO_DEPTH words
o_fEmpty  out  1  FIFO holds 0 words
o_Level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_fBusy  out  1  state != IDLE
o_fDone  out  1  one-cycle pulse in the last clock of the last stop bit
o_fOverflow  out  1  sticky: a write was dropped because the FIFO was full
o_Tx  out  1  serial line, registered output, idle high

Behaviour:
- Reset, asynchronous, any time including mid-frame: o_Tx=1; FIFO emptied (o_Level=0, o_fEmpty=1, o_fFull=0); state IDLE; o_fBusy=0; o_fDone=0; o_fOverflow=0; bit and clock counters=0.
- FIFO write: i_fWr=1 with o_fFull=0 stores i_Data at the edge. i_fWr=1 with o_fFull=1 drops the word and sets o_fOverflow at that edge. The full check uses the pre-edge state, so a write into a full FIFO is dropped even when a pop happens in the same cycle.
- Simultaneous push and pop (FIFO not full) leaves o_Level unchanged.
- o_fOverflow clears on i_fClrOvf=1. If i_fClrOvf and a dropped write occur in the same cycle, set wins.
- There is no bypass path; every word passes through the FIFO.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
- IDLE: when FIFO not empty, at the edge: pop the head word, latch word, i_ParityEn, i_ParityOdd and i_TwoStop into frame registers, go to START, drive o_Tx=0. Config inputs are ignored for the rest of the frame.
- Latency: word written at edge k -> o_Tx low from edge k+1 when idle and the FIFO was empty.
- Each bit period lasts exactly CLKS_PER_BIT clocks. The clock counter runs 0..CLKS_PER_BIT-1; the bit advances when the counter reaches CLKS_PER_BIT-1.
- START: o_Tx=0 for one bit period.
- DATA: DATA_BITS bits, LSB first.
- PARITY (entered only when latched ParityEn=1): bit = XOR of the data bits, inverted when latched ParityOdd=1.
- STOP: o_Tx=1 for 1 or 2 bit periods per latched TwoStop. o_fDone=1 in the final clock of the final stop bit.
- End of stop: if the FIFO is not empty, pop the next word and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + ParityEn + 1 + TwoStop) * CLKS_PER_BIT clocks.
- o_Level, o_fFull, o_fEmpty are updated registered-consistent with the FIFO pointers after each edge. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. Defaults, parity off, 1 stop; write 0xA5 once -> o_Tx low 1 cycle after the write edge. Line sequence, each bit 434 clocks: 0,1,0,1,0,0,1,0,1,1. o_fDone pulses at clock 4340 of the frame. o_fBusy falls afterwards.
2. i_ParityEn=1, even; send 0xA5 -> parity bit 0, frame 4774 clocks. Repeat with i_ParityOdd=1 -> parity bit 1. Repeat with i_TwoStop=1, odd -> 12-bit frame, 5208 clocks.
3. From idle, write 18 words on consecutive cycles -> word 1 popped immediately. o_fFull=1 after write 17, o_Level=16. Write 18 dropped, o_fOverflow=1. i_fClrOvf pulse clears it. Line carries words 1..17 in order.
4. Queue 0x01, 0x02, 0x03, then toggle i_TwoStop mid-frame -> three contiguous frames with no idle gap between them. The active frame is unaffected by the toggle; the next frame uses the new setting. Exactly three o_fDone pulses.
5. Assert i_Rst=0 mid-data-bit with 5 words queued -> o_Tx=1 immediately, o_Level=0, o_fBusy=0. After release, no transmission until a new write.
6. DATA_BITS=9, BAUD=12_500_000 (CLKS_PER_BIT=4); send 0x1FF with even parity -> parity bit 1, frame 48 clocks.
